ptw_mem_responder: RTL and testbench
====================================

Name: ptw_mem_responder

Overview:
- Responder end of the MMU page-table-walk (PTW) read interface. Accepts `ptw_req_valid`/`ptw_req_addr` from `mmu` and returns one PTE per request on `ptw_resp_data`/`ptw_resp_valid`.
- Converts each PTW read into a single read on a valid/ready data-memory port, with variable memory latency.
- Supports Sv32 (XLEN=32) and Sv39 (XLEN=64) PTE widths over a 64-bit memory bus.
- Sits between `mmu` and the data-memory arbiter.

Parameters:
- XLEN, 64, PTE/address width; 32 selects Sv32 behaviour, 64 selects Sv39.
- MEM_W, 64, memory read-data width; fixed at 64.
- TIMEOUT_CYCLES, 64, cycles in WAIT without a memory response before an error response is returned.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- ptw_req_valid  in  1  MMU PTE read request; held until accepted
- ptw_req_addr  in  XLEN  physical PTE address
- ptw_req_ready  out  1  request accepted when ptw_req_valid && ptw_req_ready
- ptw_resp_data  out  XLEN  PTE value; valid only while ptw_resp_valid
- ptw_resp_valid  out  1  one-cycle response pulse
- ptw_resp_err  out  1  qualifies ptw_resp_valid: misaligned, timeout or access fault; data forced 0
- mem_req_valid  out  1  memory read request
- mem_req_addr  out  XLEN  doubleword-aligned address ({addr[XLEN-1:3],3'b0})
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory read data valid
- mem_resp_data  in  MEM_W  read doubleword
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous, active-low. On reset: state=IDLE, ptw_req_ready=1, ptw_resp_valid=0, ptw_resp_err=0, ptw_resp_data=0, mem_req_valid=0, mem_req_addr=0, timeout counter=0.
- Reset asserted mid-operation abandons the transaction. A stale mem_resp_valid arriving in IDLE is ignored.
- States:
  - IDLE: ptw_req_ready=1. On accept, latch the address.
    - Address misaligned (XLEN=64: addr[2:0]!=0; XLEN=32: addr[1:0]!=0) -> RESP with err=1, no memory access.
    - Otherwise -> REQ.
  - REQ: mem_req_valid=1, address stable. On mem_req_ready -> WAIT and clear the counter. mem_req_valid drops the cycle after the handshake.
  - WAIT: counter increments each cycle.
    - On mem_resp_valid: capture data, go to RESP with err=0.
    - If counter reaches TIMEOUT_CYCLES-1 with no response: go to RESP with err=1, data=0.
    - If mem_resp_valid and timeout occur in the same cycle, the response wins.
  - RESP: ptw_resp_valid=1 for exactly one cycle, then IDLE. ptw_req_ready=0 in this cycle.
- ptw_req_ready=0 in REQ, WAIT and RESP. Only one outstanding request; no pipelining.
- Data selection:
  - XLEN=64: ptw_resp_data = mem_resp_data.
  - XLEN=32: ptw_resp_data = addr[2] ? mem_resp_data[63:32] : mem_resp_data[31:0].
- Latency with zero-wait memory (mem_req_ready=1, response the cycle after the handshake): accept at cycle N, mem_req_valid at N+1, mem_resp_valid at N+2, ptw_resp_valid at N+3.
- An erroring response carries data 0 (V=0), so `mmu` raises a page fault with no change to `mmu`.
- ptw_resp_data holds its last value outside the pulse.

Optional Feature:
- Macro: PTW_PMA_CHECK_EN.
- With the macro defined:
  - Local parameters PMA_BASE=0 and PMA_SIZE=0x0010_0000 define the legal PTE region.
  - An accepted address outside [PMA_BASE, PMA_BASE+PMA_SIZE) goes IDLE -> RESP with err=1 and data 0; no memory request is issued.
  - The check happens in IDLE together with the alignment check.
- Without the macro: no range check, and every aligned address is forwarded to memory.

Test Plan:
- XLEN=64, zero-wait memory: request 0x10000, memory returns 0x0000_0000_0000_0801 -> mem_req_addr=0x10000; ptw_resp_valid at accept+3 with data 0x801, err=0; ptw_req_ready=0 during the transaction.
- XLEN=32: request 0x20004, memory returns 0x0000_08CB_0000_1001 -> data=0x000008CB. Request 0x20000 with the same data -> data=0x00001001.
- Misaligned 0x10004 at XLEN=64 -> no mem_req_valid; ptw_resp_valid one cycle after accept with err=1, data=0.
- mem_req_ready held 0 for 5 cycles, then response after 3 cycles -> mem_req_valid and mem_req_addr stable throughout; exactly one ptw_resp_valid pulse.
- Timeout case, TIMEOUT_CYCLES=8, no mem_resp_valid -> ptw_resp_valid with err=1, data=0 exactly 8 cycles after entering WAIT. A late mem_resp_valid arriving in IDLE produces no output.
- reset_n=0 for one cycle while in WAIT -> next cycle state IDLE, ptw_req_ready=1, mem_req_valid=0, no response pulse. With PTW_PMA_CHECK_EN, request 0x200000 -> err=1, no memory access.

Source files
------------

// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder
// Responder end of the MMU page-table-walk read interface. Each accepted PTE
// read becomes exactly one doubleword read on a valid/ready memory port; the
// PTE (or an error with data 0) comes back as a one-cycle response pulse.
// XLEN=64 selects Sv39 (full doubleword), XLEN=32 selects Sv32 (word chosen
// by address bit 2). Memory latency is variable and bounded by TIMEOUT_CYCLES.
// Optional build macro PTW_PMA_CHECK_EN restricts legal PTE addresses to a
// fixed physical region checked at accept time.
// All outputs are registered; reset is synchronous, active-low.
module ptw_mem_responder #(
  parameter int XLEN           = 64,
  parameter int MEM_W          = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ptw_req_valid,
  input  logic [XLEN-1:0]  ptw_req_addr,
  output logic             ptw_req_ready,
  output logic [XLEN-1:0]  ptw_resp_data,
  output logic             ptw_resp_valid,
  output logic             ptw_resp_err,
  output logic             mem_req_valid,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  input  logic [MEM_W-1:0] mem_resp_data,
  output logic             busy
);

  // Counter just wide enough to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;

  logic              accept_s;
  logic              misalign_s;
  logic              pma_fault_s;
  logic              reject_s;
  logic              timeout_s;
  logic [MEM_W-1:0]  shifted_s;
  logic [XLEN-1:0]   dsel_s;

  logic              ptw_req_ready_r;
  logic              ptw_resp_valid_r;
  logic              ptw_resp_err_r;
  logic [XLEN-1:0]   ptw_resp_data_r;
  logic              mem_req_valid_r;
  logic [XLEN-1:0]   mem_req_addr_r;
  logic              busy_r;
  logic              word_hi_r;

  logic              resp_err_nxt_s;
  logic [XLEN-1:0]   resp_data_nxt_s;

  assign ptw_req_ready  = ptw_req_ready_r;
  assign ptw_resp_valid = ptw_resp_valid_r;
  assign ptw_resp_err   = ptw_resp_err_r;
  assign ptw_resp_data  = ptw_resp_data_r;
  assign mem_req_valid  = mem_req_valid_r;
  assign mem_req_addr   = mem_req_addr_r;
  assign busy           = busy_r;

  // A request is only ever taken in IDLE, where the registered ready is high.
  assign accept_s  = (state_r == ST_IDLE) && ptw_req_valid;
  assign reject_s  = misalign_s || pma_fault_s;
  assign timeout_s = (cnt_r == CNT_LAST);

`ifdef PTW_PMA_CHECK_EN
  // Legal PTE region; offset compare keeps the check a single unsigned test.
  localparam logic [XLEN-1:0] PMA_BASE = '0;
  localparam logic [XLEN-1:0] PMA_SIZE = XLEN'(64'h0000_0000_0010_0000);
  logic [XLEN-1:0] pma_off_s;
  assign pma_off_s   = ptw_req_addr - PMA_BASE;
  assign pma_fault_s = (pma_off_s >= PMA_SIZE);
`else
  assign pma_fault_s = 1'b0;
`endif

  // PTE alignment depends on PTE size: 8 bytes for Sv39, 4 bytes for Sv32.
  always_comb begin
    misalign_s = 1'b0;
    if (XLEN == 32) begin
      misalign_s = (ptw_req_addr[1:0] != 2'b00);
    end else begin
      misalign_s = (ptw_req_addr[2:0] != 3'b000);
    end
  end

  // Pick the PTE out of the returned doubleword (upper word for Sv32 addr[2]=1).
  always_comb begin
    shifted_s = mem_resp_data >> (word_hi_r ? 7'd32 : 7'd0);
    dsel_s    = shifted_s[XLEN-1:0];
  end

  // Next-state logic for the single-outstanding-request sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (reject_s) begin
            state_nxt_s = ST_RESP;
          end else begin
            state_nxt_s = ST_REQ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        // A response landing on the timeout cycle still wins.
        if (mem_resp_valid) begin
          state_nxt_s = ST_RESP;
        end else if (timeout_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Wait counter: zero outside WAIT so it starts from 0 on every WAIT entry.
  always_comb begin
    cnt_nxt_s = '0;
    case (state_r)
      ST_WAIT: begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
      default: begin
        cnt_nxt_s = '0;
      end
    endcase
  end

  // Response payload: error responses carry zero so the MMU sees V=0.
  always_comb begin
    resp_err_nxt_s  = 1'b0;
    resp_data_nxt_s = ptw_resp_data_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && reject_s) begin
          resp_err_nxt_s  = 1'b1;
          resp_data_nxt_s = '0;
        end else begin
          resp_data_nxt_s = ptw_resp_data_r;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          resp_err_nxt_s  = 1'b0;
          resp_data_nxt_s = dsel_s;
        end else if (timeout_s) begin
          resp_err_nxt_s  = 1'b1;
          resp_data_nxt_s = '0;
        end else begin
          resp_data_nxt_s = ptw_resp_data_r;
        end
      end
      default: begin
        resp_data_nxt_s = ptw_resp_data_r;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Registered handshake/status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptw_req_ready_r  <= 1'b1;
      ptw_resp_valid_r <= 1'b0;
      mem_req_valid_r  <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      ptw_req_ready_r  <= (state_nxt_s == ST_IDLE);
      ptw_resp_valid_r <= (state_nxt_s == ST_RESP);
      mem_req_valid_r  <= (state_nxt_s == ST_REQ);
      busy_r           <= (state_nxt_s != ST_IDLE);
    end
  end

  // Response data/error registers; data holds between pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptw_resp_err_r  <= 1'b0;
      ptw_resp_data_r <= '0;
    end else begin
      ptw_resp_err_r  <= resp_err_nxt_s;
      ptw_resp_data_r <= resp_data_nxt_s;
    end
  end

  // Latch the doubleword address and Sv32 word select when a request is forwarded.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_req_addr_r <= '0;
      word_hi_r      <= 1'b0;
    end else if (accept_s && !reject_s) begin
      mem_req_addr_r <= {ptw_req_addr[XLEN-1:3], 3'b000};
      word_hi_r      <= (XLEN == 32) ? ptw_req_addr[2] : 1'b0;
    end else begin
      mem_req_addr_r <= mem_req_addr_r;
      word_hi_r      <= word_hi_r;
    end
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Bench for ptw_mem_responder: one Sv39 (XLEN=64) and one Sv32 (XLEN=32)
// instance, both with an 8-cycle timeout. Table vectors, hand sequences for
// reset/stale responses, then randomized transactions against a latency and
// data model derived directly from the protocol rules.
module tb_ptw_mem_responder;

  localparam int TO = 8;
  localparam int NCYC = 28;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        mem_req_ready_i;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_data_i;
  int          cur_sel;

  logic        v64_in, v32_in;
  logic        r64_ready, r64_valid, r64_err, m64_valid, b64;
  logic [63:0] r64_data, m64_addr;
  logic        r32_ready, r32_valid, r32_err, m32_valid, b32;
  logic [31:0] r32_data, m32_addr, a32_in;

  logic        o_ready, o_valid, o_err, o_mvalid, o_busy;
  logic [63:0] o_data, o_maddr;

  int checks = 0;
  int failures = 0;

  assign v64_in = req_valid && (cur_sel == 0);
  assign v32_in = req_valid && (cur_sel == 1);
  assign a32_in = req_addr[31:0];

  assign o_ready  = (cur_sel == 1) ? r32_ready : r64_ready;
  assign o_valid  = (cur_sel == 1) ? r32_valid : r64_valid;
  assign o_err    = (cur_sel == 1) ? r32_err   : r64_err;
  assign o_mvalid = (cur_sel == 1) ? m32_valid : m64_valid;
  assign o_busy   = (cur_sel == 1) ? b32       : b64;
  assign o_data   = (cur_sel == 1) ? {32'h0, r32_data} : r64_data;
  assign o_maddr  = (cur_sel == 1) ? {32'h0, m32_addr} : m64_addr;

  ptw_mem_responder #(.XLEN(64), .MEM_W(64), .TIMEOUT_CYCLES(TO)) u_d64 (
    .clk(clk), .reset_n(reset_n),
    .ptw_req_valid(v64_in), .ptw_req_addr(req_addr), .ptw_req_ready(r64_ready),
    .ptw_resp_data(r64_data), .ptw_resp_valid(r64_valid), .ptw_resp_err(r64_err),
    .mem_req_valid(m64_valid), .mem_req_addr(m64_addr), .mem_req_ready(mem_req_ready_i),
    .mem_resp_valid(mem_resp_valid_i), .mem_resp_data(mem_resp_data_i), .busy(b64)
  );

  ptw_mem_responder #(.XLEN(32), .MEM_W(64), .TIMEOUT_CYCLES(TO)) u_d32 (
    .clk(clk), .reset_n(reset_n),
    .ptw_req_valid(v32_in), .ptw_req_addr(a32_in), .ptw_req_ready(r32_ready),
    .ptw_resp_data(r32_data), .ptw_resp_valid(r32_valid), .ptw_resp_err(r32_err),
    .mem_req_valid(m32_valid), .mem_req_addr(m32_addr), .mem_req_ready(mem_req_ready_i),
    .mem_resp_valid(mem_resp_valid_i), .mem_resp_data(mem_resp_data_i), .busy(b32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [63:0] addr;
    logic [63:0] md;
    int          rdy;
    int          rsp;
    logic        err;
    logic [63:0] data;
    int          lat;
    int          memc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: outcome of one transaction from the protocol rules alone.
  task automatic model(input int sel, input logic [63:0] addr, input logic [63:0] md,
                       input int rdy, input int rsp, output logic err,
                       output logic [63:0] data, output int lat, output int memc);
    logic mis;
    logic oor;
    mis = (sel == 1) ? (addr[1:0] != 2'b00) : (addr[2:0] != 3'b000);
    oor = 1'b0;
`ifdef PTW_PMA_CHECK_EN
    oor = (addr >= 64'h10_0000);
`endif
    if (mis || oor) begin
      err = 1'b1; data = 64'h0; lat = 1; memc = 0;
    end else begin
      memc = rdy + 1;
      if (rsp < TO) begin
        err = 1'b0;
        lat = rdy + rsp + 3;
        if (sel == 1) data = addr[2] ? {32'h0, md[63:32]} : {32'h0, md[31:0]};
        else          data = md;
      end else begin
        err = 1'b1; data = 64'h0; lat = rdy + TO + 2;
      end
    end
  endtask

  // Drive one request and an emulated memory, then compare the observed trace.
  task automatic run_txn(input string tag, input int sel, input logic [63:0] addr,
                         input logic [63:0] md, input int rdy, input int rsp,
                         input logic exp_err, input logic [63:0] exp_data,
                         input int exp_lat, input int exp_memc);
    int pulses = 0, lat_act = -1, memc = 0, hs_c = -1;
    logic err_act = 1'b0;
    logic [63:0] data_act = 64'h0, hold_data = 64'h0, exp_maddr;
    logic addr_bad = 1'b0, ready_bad = 1'b0, busy_bad = 1'b0;
    logic idle_exp;
    exp_maddr = {addr[63:3], 3'b000};
    cur_sel = sel;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      idle_exp = (c == 0) || (c > exp_lat);
      if (o_ready !== idle_exp) ready_bad = 1'b1;
      if (o_busy !== !idle_exp) busy_bad = 1'b1;
      if (o_valid === 1'b1) begin
        pulses++;
        if (lat_act < 0) begin
          lat_act = c; data_act = o_data; err_act = o_err;
        end
      end
      if (c == exp_lat + 2) hold_data = o_data;
      if (o_mvalid === 1'b1) begin
        memc++;
        if (o_maddr !== exp_maddr) addr_bad = 1'b1;
      end
      req_valid = (c == 0);
      req_addr  = addr;
      mem_req_ready_i = (o_mvalid === 1'b1) && (memc > rdy);
      if (mem_req_ready_i) hs_c = c;
      mem_resp_valid_i = (hs_c >= 0) && (c == hs_c + 1 + rsp);
      mem_resp_data_i  = mem_resp_valid_i ? md : {$urandom, $urandom};
    end
    req_valid = 1'b0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_lat"}, 64'(lat_act), 64'(exp_lat));
    chk({tag, "_err"}, {63'h0, err_act}, {63'h0, exp_err});
    chk({tag, "_data"}, data_act, exp_data);
    chk({tag, "_hold"}, hold_data, exp_data);
    chk({tag, "_memc"}, 64'(memc), 64'(exp_memc));
    chk({tag, "_maddr_bad"}, {63'h0, addr_bad}, 64'h0);
    chk({tag, "_ready_bad"}, {63'h0, ready_bad}, 64'h0);
    chk({tag, "_busy_bad"}, {63'h0, busy_bad}, 64'h0);
  endtask

  initial begin
    logic        e_err;
    logic [63:0] e_data, r_addr, r_md;
    int          e_lat, e_memc, r_sel, r_rdy, r_rsp, npulse;

    tbl[0]  = '{0, 64'h1_0000, 64'h801, 0, 0, 1'b0, 64'h801, 3, 1};
    tbl[1]  = '{1, 64'h2_0004, 64'h0000_08CB_0000_1001, 0, 0, 1'b0, 64'h8CB, 3, 1};
    tbl[2]  = '{1, 64'h2_0000, 64'h0000_08CB_0000_1001, 0, 0, 1'b0, 64'h1001, 3, 1};
    tbl[3]  = '{0, 64'h1_0004, 64'h55, 0, 0, 1'b1, 64'h0, 1, 0};
    tbl[4]  = '{0, 64'h3_0008, 64'hDEAD_BEEF_0000_0C01, 5, 3, 1'b0, 64'hDEAD_BEEF_0000_0C01, 11, 6};
    tbl[5]  = '{0, 64'h4_0000, 64'h123, 0, 20, 1'b1, 64'h0, 10, 1};
    tbl[6]  = '{0, 64'h4_0008, 64'hABC, 0, 7, 1'b0, 64'hABC, 10, 1};
    tbl[7]  = '{1, 64'h2_0002, 64'h77, 0, 0, 1'b1, 64'h0, 1, 0};
    tbl[8]  = '{1, 64'h2_000C, 64'h1111_2222_3333_4444, 2, 1, 1'b0, 64'h1111_2222, 6, 3};
    tbl[9]  = '{1, 64'h2_0004, 64'h99, 0, 8, 1'b1, 64'h0, 10, 1};
`ifdef PTW_PMA_CHECK_EN
    tbl[10] = '{0, 64'h20_0000, 64'hF01, 0, 0, 1'b1, 64'h0, 1, 0};
`else
    tbl[10] = '{0, 64'h20_0000, 64'hF01, 0, 0, 1'b0, 64'hF01, 3, 1};
`endif

    reset_n = 1'b0; req_valid = 1'b0; req_addr = 64'h0; cur_sel = 0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = 64'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst64_ready", {63'h0, r64_ready}, 64'h1);
    chk("rst64_valid", {63'h0, r64_valid}, 64'h0);
    chk("rst64_err",   {63'h0, r64_err},   64'h0);
    chk("rst64_data",  r64_data,           64'h0);
    chk("rst64_mvalid", {63'h0, m64_valid}, 64'h0);
    chk("rst64_maddr", m64_addr,           64'h0);
    chk("rst64_busy",  {63'h0, b64},       64'h0);
    chk("rst32_ready", {63'h0, r32_ready}, 64'h1);
    chk("rst32_data",  {32'h0, r32_data},  64'h0);
    chk("rst32_maddr", {32'h0, m32_addr},  64'h0);

    for (int i = 0; i < 11; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].sel, tbl[i].addr, tbl[i].md, tbl[i].rdy,
              tbl[i].rsp, tbl[i].err, tbl[i].data, tbl[i].lat, tbl[i].memc);
    end

    // Reset for one cycle while waiting on memory abandons the transaction.
    cur_sel = 0;
    @(negedge clk); req_valid = 1'b1; req_addr = 64'h5_0000;
    @(negedge clk); req_valid = 1'b0;
    chk("rstmid_mvalid", {63'h0, o_mvalid}, 64'h1);
    mem_req_ready_i = 1'b1;
    @(negedge clk); mem_req_ready_i = 1'b0;
    chk("rstmid_busy_wait", {63'h0, o_busy}, 64'h1);
    reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk("rstmid_ready", {63'h0, o_ready}, 64'h1);
    chk("rstmid_mvalid0", {63'h0, o_mvalid}, 64'h0);
    chk("rstmid_busy", {63'h0, o_busy}, 64'h0);
    chk("rstmid_data", o_data, 64'h0);
    // Stale memory response arriving in IDLE must be ignored.
    mem_resp_valid_i = 1'b1; mem_resp_data_i = 64'hFFFF_0000_FFFF_0001;
    npulse = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_resp_valid_i = 1'b0;
      if (o_valid === 1'b1) npulse++;
    end
    chk("stale_pulses", 64'(npulse), 64'h0);
    chk("stale_ready", {63'h0, o_ready}, 64'h1);
    chk("stale_data", o_data, 64'h0);

    for (int i = 0; i < 40; i++) begin
      r_sel  = int'($urandom_range(0, 1));
      r_addr = 64'($urandom_range(0, 32'h1F_FFFF));
      if ($urandom_range(0, 3) != 0) r_addr = {r_addr[63:3], 3'b000};
      r_md   = {$urandom, $urandom};
      r_rdy  = int'($urandom_range(0, 4));
      r_rsp  = int'($urandom_range(0, 12));
      model(r_sel, r_addr, r_md, r_rdy, r_rsp, e_err, e_data, e_lat, e_memc);
      run_txn($sformatf("rnd%0d", i), r_sel, r_addr, r_md, r_rdy, r_rsp,
              e_err, e_data, e_lat, e_memc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
